// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer
// Arms, soft-start ramps, runs and stops the wall-follower drive path.
// Gates the PID controller and supplies the shared base duty to the duty adders.
// All timing is counted in tick_en periods.
// Optional feature: define SEQ_WATCHDOG_EN to add a RUN-state feedback watchdog.
//
// Handshake note: there is no valid/ready pairing here. start_pulse, tick_en and
// fb_valid are single-cycle pulses sampled on every clk edge; stop_sw and
// bump_hit are levels. Every output is a flop and updates on the edge after the
// inputs that caused it.
module motor_drive_sequencer #(
    parameter int PWM_RESOLUTION = 17,
    parameter int BASE_DUTY      = 32768,
    parameter int RAMP_STEP      = 2048,
    parameter int ARM_TICKS      = 16,
    parameter int HOLDOFF_TICKS  = 32,
    parameter int WDOG_TICKS     = 8,
    parameter int TICK_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_en,
    input  logic                      start_pulse,
    input  logic                      stop_sw,
    input  logic                      bump_hit,
    input  logic                      fb_valid,
    output logic                      motor_en,
    output logic [PWM_RESOLUTION-1:0] base_duty,
    output logic                      pid_en,
    output logic                      pid_clr,
    output logic                      fault,
    output logic [2:0]                state_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RAMP = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    // Ramp arithmetic is one bit wider than base_duty so the sum cannot wrap.
    localparam logic [PWM_RESOLUTION:0]   STEP_X    = (PWM_RESOLUTION+1)'(RAMP_STEP);
    localparam logic [PWM_RESOLUTION:0]   BASE_X    = (PWM_RESOLUTION+1)'(BASE_DUTY);
    localparam logic [PWM_RESOLUTION-1:0] BASE_D    = PWM_RESOLUTION'(BASE_DUTY);
    localparam logic [TICK_CNT_WIDTH-1:0] ARM_LAST  = TICK_CNT_WIDTH'(ARM_TICKS - 1);
    localparam logic [TICK_CNT_WIDTH-1:0] HOLD_LAST = TICK_CNT_WIDTH'(HOLDOFF_TICKS - 1);
`ifdef SEQ_WATCHDOG_EN
    localparam logic [TICK_CNT_WIDTH-1:0] WDOG_LAST = TICK_CNT_WIDTH'(WDOG_TICKS - 1);
`else
    localparam int unused_wdog_ticks = WDOG_TICKS;
    logic unused_fb_valid;
    assign unused_fb_valid = fb_valid;
`endif

    state_t                    state, state_d;
    logic [TICK_CNT_WIDTH-1:0] cnt, cnt_d, cnt_inc;
    logic [PWM_RESOLUTION-1:0] duty_d;
    logic [PWM_RESOLUTION:0]   ramp_sum;
    logic                      fault_d;

    // Next-state, next counter, next duty and next fault, in priority order.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        duty_d   = base_duty;
        fault_d  = fault;
        ramp_sum = {1'b0, base_duty} + STEP_X;
        cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

        if (stop_sw) begin
            state_d = S_IDLE;
        end else if (bump_hit && (state == S_RAMP || state == S_RUN)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
        end else if (start_pulse && (state == S_ARM || state == S_RAMP || state == S_RUN)) begin
            state_d = S_HALT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_pulse && !bump_hit) begin
                        state_d = S_ARM;
                        fault_d = 1'b0;
                    end
                end
                S_ARM: begin
                    if (tick_en) begin
                        if (cnt == ARM_LAST) state_d = S_RAMP;
                        else                 cnt_d   = cnt_inc;
                    end
                end
                S_RAMP: begin
                    if (tick_en) begin
                        if (ramp_sum >= BASE_X) begin
                            duty_d  = BASE_D;
                            state_d = S_RUN;
                        end else begin
                            duty_d = ramp_sum[PWM_RESOLUTION-1:0];
                        end
                    end
                end
                S_RUN: begin
                    duty_d = BASE_D;
`ifdef SEQ_WATCHDOG_EN
                    // Fresh feedback clears the watchdog even on a tick.
                    if (fb_valid) begin
                        cnt_d = '0;
                    end else if (tick_en) begin
                        if (cnt == WDOG_LAST) begin
                            state_d = S_HALT;
                            fault_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
`endif
                end
                S_HALT: begin
                    if (tick_en) begin
                        if (cnt == HOLD_LAST) state_d = S_IDLE;
                        else                  cnt_d   = cnt_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A state change consumes any coincident tick and restarts the count.
        if (state_d != state) cnt_d = '0;
        // Duty is only non-zero while the motors are driven.
        if (state_d != S_RAMP && state_d != S_RUN) duty_d = '0;
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            base_duty <= '0;
            fault     <= 1'b0;
            motor_en  <= 1'b0;
            pid_en    <= 1'b0;
            pid_clr   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            base_duty <= duty_d;
            fault     <= fault_d;
            motor_en  <= (state_d == S_RAMP) || (state_d == S_RUN);
            pid_en    <= (state_d == S_RUN);
            pid_clr   <= (state_d == S_RUN) && (state != S_RUN);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer
// Directed bench for motor_drive_sequencer with a behavioural reference model.
// Honours SEQ_WATCHDOG_EN the same way the design does.
module tb_motor_drive_sequencer;

    localparam int PWM_RESOLUTION = 17;
    localparam int BASE_DUTY      = 32768;
    localparam int RAMP_STEP      = 2048;
    localparam int ARM_TICKS      = 16;
    localparam int HOLDOFF_TICKS  = 32;
    localparam int WDOG_TICKS     = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic tick_en = 1'b0, start_pulse = 1'b0, stop_sw = 1'b0, bump_hit = 1'b0, fb_valid = 1'b0;

    logic                      motor_en, pid_en, pid_clr, fault;
    logic [PWM_RESOLUTION-1:0] base_duty;
    logic [2:0]                state_out;

    logic                      motor_en2, pid_en2, pid_clr2, fault2;
    logic [PWM_RESOLUTION-1:0] base_duty2;
    logic [2:0]                state_out2;

    motor_drive_sequencer dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .start_pulse(start_pulse),
        .stop_sw(stop_sw), .bump_hit(bump_hit), .fb_valid(fb_valid),
        .motor_en(motor_en), .base_duty(base_duty), .pid_en(pid_en),
        .pid_clr(pid_clr), .fault(fault), .state_out(state_out)
    );

    // Coarse-step instance for the non-exact saturation case.
    motor_drive_sequencer #(.RAMP_STEP(5000)) dut2 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .start_pulse(start_pulse),
        .stop_sw(stop_sw), .bump_hit(bump_hit), .fb_valid(fb_valid),
        .motor_en(motor_en2), .base_duty(base_duty2), .pid_en(pid_en2),
        .pid_clr(pid_clr2), .fault(fault2), .state_out(state_out2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode numbers follow the published encoding; ramp progress is kept as a
    // count of ramp ticks and the duty is derived from it by multiplication.
    int m_mode, m_ticks, m_steps, m_wd, nxt;
    bit m_fault, m_run_entry, m_valid;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_ticks = 0; m_steps = 0; m_wd = 0;
            m_fault = 0; m_run_entry = 0; m_valid = 1;
        end else begin
            nxt = m_mode;
            m_run_entry = 0;
            if (stop_sw) nxt = 0;
            else if (bump_hit && (m_mode == 2 || m_mode == 3)) begin
                nxt = 4; m_fault = 1;
            end else if (start_pulse && m_mode >= 1 && m_mode <= 3) nxt = 4;
            else begin
                case (m_mode)
                    0: if (start_pulse && !bump_hit) begin nxt = 1; m_fault = 0; end
                    1: if (tick_en) begin
                           if (m_ticks + 1 == ARM_TICKS) nxt = 2; else m_ticks++;
                       end
                    2: if (tick_en) begin
                           m_steps++;
                           if (m_steps * RAMP_STEP >= BASE_DUTY) nxt = 3;
                       end
                    3: begin
`ifdef SEQ_WATCHDOG_EN
                        if (fb_valid) m_wd = 0;
                        else if (tick_en) begin
                            if (m_wd + 1 == WDOG_TICKS) begin nxt = 4; m_fault = 1; end
                            else m_wd++;
                        end
`endif
                    end
                    4: if (tick_en) begin
                           if (m_ticks + 1 == HOLDOFF_TICKS) nxt = 0; else m_ticks++;
                       end
                    default: nxt = 0;
                endcase
            end
            if (nxt != m_mode) begin
                m_ticks = 0; m_steps = 0; m_wd = 0;
                m_run_entry = (nxt == 3);
            end
            m_mode = nxt;
        end
    end

    function automatic int exp_duty();
        if (m_mode == 3) return BASE_DUTY;
        if (m_mode == 2) return m_steps * RAMP_STEP;
        return 0;
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state_out", 32'(state_out), 32'(m_mode));
            chk("motor_en",  32'(motor_en),  32'(m_mode == 2 || m_mode == 3));
            chk("base_duty", 32'(base_duty), 32'(exp_duty()));
            chk("pid_en",    32'(pid_en),    32'(m_mode == 3));
            chk("pid_clr",   32'(pid_clr),   32'(m_run_entry));
            chk("fault",     32'(fault),     32'(m_fault));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit t, input bit s, input bit f);
        @(negedge clk);
        tick_en = t; start_pulse = s; fb_valid = f;
        @(posedge clk);
        #1;
        tick_en = 0; start_pulse = 0; fb_valid = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
    endtask

    // Overall time limit.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) cycle(0, 0, 0);
        chk("reset state_out", 32'(state_out), 0);
        chk("reset base_duty", 32'(base_duty), 0);
        chk("reset fault",     32'(fault),     0);
        reset = 0;
        repeat (10) cycle(0, 0, 0);

        // Arm, ramp, enter RUN.
        cycle(0, 1, 0);
        chk("arm state", 32'(state_out), 1);
        ticks(15);
        chk("arm hold", 32'(state_out), 1);
        ticks(1);
        chk("ramp state", 32'(state_out), 2);
        chk("ramp motor_en", 32'(motor_en), 1);
        chk("ramp duty0", 32'(base_duty), 0);
        for (int k = 1; k <= 6; k++) begin
            ticks(1);
            chk("ramp duty", 32'(base_duty), 32'(k * 2048));
            chk("coarse duty", 32'(base_duty2), 32'(k * 5000));
        end
        ticks(1);
        chk("coarse sat duty", 32'(base_duty2), 32768);
        chk("coarse run", 32'(state_out2), 3);
        ticks(8);
        chk("ramp duty15", 32'(base_duty), 30720);
        chk("ramp state15", 32'(state_out), 2);
        cycle(1, 0, 0);
        chk("run state", 32'(state_out), 3);
        chk("run duty", 32'(base_duty), 32768);
        chk("run pid_clr", 32'(pid_clr), 1);
        chk("run pid_en", 32'(pid_en), 1);
        cycle(0, 0, 0);
        chk("run pid_clr off", 32'(pid_clr), 0);

        // Feedback arriving every seventh tick keeps RUN alive.
        for (int r = 0; r < 3; r++) begin
            ticks(6);
            cycle(1, 0, 1);
        end
        chk("run kept", 32'(state_out), 3);

        // Bump in RUN, holdoff, re-arm clears fault.
        bump_hit = 1;
        cycle(0, 0, 0);
        bump_hit = 0;
        chk("bump halt", 32'(state_out), 4);
        chk("bump fault", 32'(fault), 1);
        chk("bump duty", 32'(base_duty), 0);
        chk("bump motor_en", 32'(motor_en), 0);
        cycle(0, 1, 0);
        chk("halt ignores start", 32'(state_out), 4);
        ticks(31);
        chk("holdoff", 32'(state_out), 4);
        ticks(1);
        chk("back idle", 32'(state_out), 0);
        chk("fault sticky", 32'(fault), 1);
        cycle(0, 1, 0);
        chk("rearm", 32'(state_out), 1);
        chk("rearm fault clr", 32'(fault), 0);

        // Stop mid-ramp.
        ticks(16);
        ticks(4);
        chk("mid ramp duty", 32'(base_duty), 8192);
        stop_sw = 1;
        cycle(0, 0, 0);
        chk("stop idle", 32'(state_out), 0);
        chk("stop duty", 32'(base_duty), 0);
        chk("stop motor_en", 32'(motor_en), 0);
        cycle(0, 1, 0);
        chk("stop blocks start", 32'(state_out), 0);
        stop_sw = 0;

        // Start coincident with the last ARM tick: HALT wins.
        cycle(0, 1, 0);
        ticks(15);
        cycle(1, 1, 0);
        chk("arm toggle halt", 32'(state_out), 4);
        chk("arm toggle duty", 32'(base_duty), 0);
        chk("arm toggle fault", 32'(fault), 0);
        ticks(32);
        chk("arm toggle idle", 32'(state_out), 0);

        // Bump in IDLE blocks start.
        bump_hit = 1;
        cycle(0, 1, 0);
        bump_hit = 0;
        chk("idle bump", 32'(state_out), 0);

        // Back to RUN, then feedback withheld.
        cycle(0, 1, 0);
        ticks(16);
        ticks(16);
        chk("run again", 32'(state_out), 3);
        ticks(7);
        chk("wdog 7 ticks", 32'(state_out), 3);
        ticks(1);
`ifdef SEQ_WATCHDOG_EN
        chk("wdog halt", 32'(state_out), 4);
        chk("wdog fault", 32'(fault), 1);
        ticks(32);
        cycle(0, 1, 0);
        ticks(32);
`else
        chk("no wdog", 32'(state_out), 3);
`endif
        // Simultaneous start and bump in RUN counts as a bump.
        bump_hit = 1;
        cycle(0, 1, 0);
        bump_hit = 0;
        chk("start+bump halt", 32'(state_out), 4);
        chk("start+bump fault", 32'(fault), 1);
        repeat (3) cycle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
